// File: rtl/matvec_pkg.sv
// Shared constants and types for the 3x3 matrix-vector controller slice.
// Holds the matrix dimension, memory address widths, datapath widths and the
// controller state enum so the controller, its interface and the datapath agree.
package matvec_pkg;

  // Matrix dimension: K*K matrix words, K vector words, K results per product.
  localparam int K        = 3;
  localparam int M_ADDR_W = $clog2(K * K);
  localparam int X_ADDR_W = $clog2(K);

  // Datapath widths (operand word and accumulated result).
  localparam int DATA_W   = 14;
  localparam int RESULT_W = 28;

  // Word counter range covers a full matrix-plus-vector transfer.
  localparam int W_MAX    = K * K + K - 1;
  localparam int W_W      = $clog2(W_MAX + 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMP,
    S_DRAIN,
    S_OUT
  } ctrl_state_t;

endpackage

// File: rtl/matvec3_ctrl_if.sv
// Handshake and memory-control bundle between the matvec controller and its
// surroundings.
//   master : upstream/downstream side -- drives input_valid, new_matrix,
//            output_ready; observes everything else.
//   slave  : controller side -- drives input_ready, memory write/read controls,
//            accumulator controls and output_valid.
interface matvec3_ctrl_if;
  import matvec_pkg::*;

  logic                input_valid;
  logic                input_ready;
  logic                new_matrix;
  logic                m_wr_en;
  logic [M_ADDR_W-1:0] m_wr_addr;
  logic                x_wr_en;
  logic [X_ADDR_W-1:0] x_wr_addr;
  logic [M_ADDR_W-1:0] m_rd_addr;
  logic [X_ADDR_W-1:0] x_rd_addr;
  logic                acc_en;
  logic                acc_first;
  logic                output_valid;
  logic                output_ready;

  modport master (
    output input_valid, new_matrix, output_ready,
    input  input_ready, m_wr_en, m_wr_addr, x_wr_en, x_wr_addr,
           m_rd_addr, x_rd_addr, acc_en, acc_first, output_valid
  );

  modport slave (
    input  input_valid, new_matrix, output_ready,
    output input_ready, m_wr_en, m_wr_addr, x_wr_en, x_wr_addr,
           m_rd_addr, x_rd_addr, acc_en, acc_first, output_valid
  );

endinterface

// File: rtl/matvec3_cnt.sv
// Wrap-around counter with synchronous clear and enable.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset (count returns to 0)
//   clr   : force count to 0 on the next edge (wins over en)
//   en    : advance count; wraps from MAX back to 0
//   count : current count value
module matvec3_cnt
  import matvec_pkg::*;
#(
  parameter int MAX   = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == WIDTH'(MAX)) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/matvec3_ctrl.sv
// Controller for a KxK matrix times K-vector engine.
// Loads matrix/vector words into memories, sequences the row reads and the
// accumulator, and presents one result per row with a valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : slave side of matvec3_ctrl_if (input handshake, memory write and
//           read addresses, accumulator enables, output handshake)
module matvec3_ctrl #(
  parameter int K = matvec_pkg::K
) (
  input  logic           clk,
  input  logic           reset,
  matvec3_ctrl_if.slave  bus
);
  import matvec_pkg::*;

  localparam int MAT_WORDS = K * K;
  localparam int ALL_WORDS = K * K + K;

  ctrl_state_t         state_q, state_d;
  logic                mode_q, mode_d;
  logic                m_loaded_q, m_loaded_d;

  logic [W_W-1:0]      w;
  logic [X_ADDR_W-1:0] r;
  logic [X_ADDR_W-1:0] c;
  logic                w_en, w_clr, r_en, r_clr, c_en, c_clr;

  logic                accept;
  logic                mode_now;
  logic                last_word;
  logic                in_comp;

  matvec3_cnt #(.MAX(ALL_WORDS - 1), .WIDTH(W_W)) u_w_cnt (
    .clk(clk), .reset(reset), .clr(w_clr), .en(w_en), .count(w)
  );

  matvec3_cnt #(.MAX(K - 1), .WIDTH(X_ADDR_W)) u_r_cnt (
    .clk(clk), .reset(reset), .clr(r_clr), .en(r_en), .count(r)
  );

  matvec3_cnt #(.MAX(K - 1), .WIDTH(X_ADDR_W)) u_c_cnt (
    .clk(clk), .reset(reset), .clr(c_clr), .en(c_en), .count(c)
  );

  // Output decode. Everything is gated by reset so the block is silent while
  // reset is held low, whatever state the flops were in. The transfer mode is
  // taken live from new_matrix on the first word and from the latch afterwards.
  always_comb begin
    accept    = reset && (state_q == S_LOAD) && bus.input_valid;
    mode_now  = (w == '0) ? (bus.new_matrix || !m_loaded_q) : mode_q;
    last_word = mode_now ? (w == W_W'(ALL_WORDS - 1)) : (w == W_W'(K - 1));
    in_comp   = reset && (state_q == S_COMP);

    bus.input_ready  = reset && (state_q == S_LOAD);
    bus.m_wr_en      = accept && mode_now && (w < W_W'(MAT_WORDS));
    bus.x_wr_en      = accept && !(mode_now && (w < W_W'(MAT_WORDS)));
    bus.m_wr_addr    = bus.m_wr_en ? M_ADDR_W'(w) : '0;
    bus.x_wr_addr    = '0;
    if (bus.x_wr_en) begin
      bus.x_wr_addr = mode_now ? X_ADDR_W'(w - W_W'(MAT_WORDS)) : X_ADDR_W'(w);
    end

    bus.m_rd_addr    = in_comp ? (M_ADDR_W'(r) * M_ADDR_W'(K) + M_ADDR_W'(c)) : '0;
    bus.x_rd_addr    = in_comp ? c : '0;

    // The memories answer one cycle after the address, so the accumulator runs
    // one step behind the column counter; the drain cycle catches the last word.
    bus.acc_en       = (in_comp && (c != '0)) || (reset && (state_q == S_DRAIN));
    bus.acc_first    = in_comp && (c == X_ADDR_W'(1));
    bus.output_valid = reset && (state_q == S_OUT);
  end

  // Next-state and counter control.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    m_loaded_d = m_loaded_q;
    w_en       = 1'b0;
    w_clr      = 1'b0;
    r_en       = 1'b0;
    r_clr      = 1'b0;
    c_en       = 1'b0;
    c_clr      = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          w_en = 1'b1;
          if (w == '0) begin
            mode_d = mode_now;
          end
          if (mode_now && (w == W_W'(MAT_WORDS - 1))) begin
            m_loaded_d = 1'b1;
          end
          if (last_word) begin
            w_clr   = 1'b1;
            r_clr   = 1'b1;
            c_clr   = 1'b1;
            state_d = S_COMP;
          end
        end
      end
      S_COMP: begin
        c_en = 1'b1;
        if (c == X_ADDR_W'(K - 1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        // r wraps to 0 after the last row, leaving it ready for the next transfer.
        if (bus.output_ready) begin
          r_en    = 1'b1;
          c_clr   = 1'b1;
          state_d = (r == X_ADDR_W'(K - 1)) ? S_LOAD : S_COMP;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_LOAD;
      mode_q     <= 1'b0;
      m_loaded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      m_loaded_q <= m_loaded_d;
    end
  end

endmodule

// File: tb/tb_matvec3_ctrl.sv
// Self-checking bench for matvec3_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transfer/timeline model of the controller's behaviour.
module tb_matvec3_ctrl;
  import matvec_pkg::*;

  localparam int KK = K * K;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  matvec3_ctrl_if bus ();

  matvec3_ctrl #(.K(K)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit cur_rst, cur_v, cur_nm, cur_ordy;

  // Model: loading while mdl_t < 0; otherwise mdl_t counts cycles into the
  // current row (reads at 0..K-1, accumulate at 1..K, result at K+1).
  bit mdl_have_matrix;
  bit mdl_mode;
  int mdl_words;
  int mdl_row;
  int mdl_t;
  int mdl_transfers;

  int m_wr_log[$];
  int x_wr_log[$];
  int accepts;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void clearLogs();
    m_wr_log.delete();
    x_wr_log.delete();
    accepts = 0;
  endfunction

  task automatic applyStimulus(input bit rst, input bit v, input bit nm, input bit ordy);
    cur_rst          = rst;
    cur_v            = v;
    cur_nm           = nm;
    cur_ordy         = ordy;
    reset            = rst;
    bus.input_valid  = v;
    bus.new_matrix   = nm;
    bus.output_ready = ordy;
  endtask

  task automatic checkOutput();
    bit loading, acc, mode, exp_mw, exp_xw, comp;
    int exp_mwa, exp_xwa, exp_mra, exp_xra;
    loading = (mdl_t < 0);
    acc     = cur_rst && loading && cur_v;
    mode    = (mdl_words == 0) ? (cur_nm || !mdl_have_matrix) : mdl_mode;
    exp_mw  = acc && mode && (mdl_words < KK);
    exp_xw  = acc && !exp_mw;
    exp_mwa = exp_mw ? mdl_words : 0;
    exp_xwa = exp_xw ? (mode ? mdl_words - KK : mdl_words) : 0;
    comp    = cur_rst && !loading && (mdl_t < K);
    exp_mra = comp ? mdl_row * K + mdl_t : 0;
    exp_xra = comp ? mdl_t : 0;

    check("input_ready",  bus.input_ready,  int'(cur_rst && loading));
    check("m_wr_en",      bus.m_wr_en,      int'(exp_mw));
    check("m_wr_addr",    bus.m_wr_addr,    exp_mwa);
    check("x_wr_en",      bus.x_wr_en,      int'(exp_xw));
    check("x_wr_addr",    bus.x_wr_addr,    exp_xwa);
    check("m_rd_addr",    bus.m_rd_addr,    exp_mra);
    check("x_rd_addr",    bus.x_rd_addr,    exp_xra);
    check("acc_en",       bus.acc_en,       int'(cur_rst && mdl_t >= 1 && mdl_t <= K));
    check("acc_first",    bus.acc_first,    int'(cur_rst && mdl_t == 1));
    check("output_valid", bus.output_valid, int'(cur_rst && mdl_t == K + 1));

    if (bus.m_wr_en) m_wr_log.push_back(int'(bus.m_wr_addr));
    if (bus.x_wr_en) x_wr_log.push_back(int'(bus.x_wr_addr));
    if (bus.input_valid && bus.input_ready) accepts++;
  endtask

  task automatic modelStep();
    bit mode;
    if (!cur_rst) begin
      mdl_have_matrix = 1'b0;
      mdl_mode        = 1'b0;
      mdl_words       = 0;
      mdl_row         = 0;
      mdl_t           = -1;
    end else if (mdl_t < 0) begin
      if (cur_v) begin
        mode = (mdl_words == 0) ? (cur_nm || !mdl_have_matrix) : mdl_mode;
        mdl_mode = mode;
        mdl_words++;
        if (mode && mdl_words == KK) mdl_have_matrix = 1'b1;
        if (mdl_words == (mode ? KK + K : K)) begin
          mdl_words = 0;
          mdl_row   = 0;
          mdl_t     = 0;
        end
      end
    end else if (mdl_t < K + 1) begin
      mdl_t++;
    end else if (cur_ordy) begin
      if (mdl_row < K - 1) begin
        mdl_row++;
        mdl_t = 0;
      end else begin
        mdl_t = -1;
        mdl_transfers++;
      end
    end
  endtask

  task automatic runCycle(input bit rst, input bit v, input bit nm, input bit ordy);
    @(negedge clk);
    applyStimulus(rst, v, nm, ordy);
    #1;
    checkOutput();
    modelStep();
  endtask

  // Counts result-free cycles, starting from 'start', until output_valid shows.
  task automatic waitValid(input int start, output int zeros);
    zeros = start;
    for (int i = 0; i < 30; i++) begin
      runCycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (bus.output_valid) break;
      zeros++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, hold_valid, hold_ready, idx, first_rd, first_acc, n_acc, n_first;
    int first_on_first, outs, cyc, start;
    int rd[$];
    int xr[$];

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    mdl_have_matrix = 1'b0;
    mdl_mode        = 1'b0;
    mdl_words       = 0;
    mdl_row         = 0;
    mdl_t           = -1;
    mdl_transfers   = 0;
    clearLogs();

    // Reset with busy inputs: nothing may be accepted.
    repeat (2) runCycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("reset_ready_low", bus.input_ready, 0);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("ready_after_reset", bus.input_ready, 1);

    // Matrix path: 12 back-to-back words.
    clearLogs();
    for (int i = 0; i < 12; i++) runCycle(1'b1, 1'b1, (i == 0), 1'b0);
    check("m_wr_count", m_wr_log.size(), 9);
    foreach (m_wr_log[i]) check("m_wr_addr_seq", m_wr_log[i], i);
    check("x_wr_count", x_wr_log.size(), 3);
    foreach (x_wr_log[i]) check("x_wr_addr_seq", x_wr_log[i], i);
    runCycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("ready_drops", bus.input_ready, 0);
    waitValid(1, lat);
    check("latency_first_row", lat, 4);

    // Backpressure on the first result.
    hold_valid = 0;
    hold_ready = 0;
    repeat (10) begin
      runCycle(1'b1, 1'b1, 1'b1, 1'b0);
      hold_valid += int'(bus.output_valid);
      hold_ready += int'(bus.input_ready);
    end
    check("bp_valid_held", hold_valid, 10);
    check("bp_ready_low", hold_ready, 0);
    runCycle(1'b1, 1'b0, 1'b0, 1'b1);

    // Row 1 read and accumulate sequence.
    idx = 0; first_rd = -1; first_acc = -1; n_acc = 0; n_first = 0; first_on_first = 0;
    do begin
      runCycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (bus.m_rd_addr != '0) begin
        rd.push_back(int'(bus.m_rd_addr));
        xr.push_back(int'(bus.x_rd_addr));
        if (first_rd < 0) first_rd = idx;
      end
      if (bus.acc_en) begin
        n_acc++;
        if (first_acc < 0) begin
          first_acc      = idx;
          first_on_first = int'(bus.acc_first);
        end
      end
      n_first += int'(bus.acc_first);
      idx++;
    end while (!bus.output_valid && idx < 30);
    check("row1_rd_count", rd.size(), 3);
    foreach (rd[i]) check("row1_m_rd_addr", rd[i], 3 + i);
    foreach (xr[i]) check("row1_x_rd_addr", xr[i], i);
    check("row1_acc_pulses", n_acc, 3);
    check("row1_acc_first_pulses", n_first, 1);
    check("row1_acc_first_on_first", first_on_first, 1);
    check("row1_acc_delay", first_acc - first_rd, 1);
    check("latency_next_row", idx - 1, 4);

    runCycle(1'b1, 1'b0, 1'b0, 1'b1);
    waitValid(0, lat);
    check("latency_last_row", lat, 4);
    runCycle(1'b1, 1'b0, 1'b0, 1'b1);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("ready_after_last_row", bus.input_ready, 1);

    // Vector-only reuse of the loaded matrix.
    clearLogs();
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("vec_m_wr_count", m_wr_log.size(), 0);
    check("vec_x_wr_count", x_wr_log.size(), 3);
    foreach (x_wr_log[i]) check("vec_x_wr_addr_seq", x_wr_log[i], i);
    runCycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("vec_ready_drops", bus.input_ready, 0);
    outs = 0;
    for (int i = 0; i < 100; i++) begin
      runCycle(1'b1, 1'b0, 1'b0, 1'b1);
      if (bus.output_valid) outs++;
      if (bus.input_ready) break;
    end
    check("vec_outputs", outs, 3);

    // After reset, new_matrix=0 still loads a full matrix.
    runCycle(1'b0, 1'b0, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0);
    clearLogs();
    idx = 0;
    do begin
      runCycle(1'b1, 1'b1, 1'b0, 1'b0);
      idx++;
    end while (bus.input_ready && idx < 40);
    check("forced_matrix_words", accepts, 12);
    check("forced_matrix_m_wr", m_wr_log.size(), 9);

    // Reset in the middle of row 1.
    waitValid(1, lat);
    check("latency_forced", lat, 4);
    runCycle(1'b1, 1'b0, 1'b0, 1'b1);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("midcomp_rd_addr", bus.m_rd_addr, 4);
    runCycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("midreset_outputs", int'(bus.input_ready) + int'(bus.m_wr_en) + int'(bus.x_wr_en)
          + int'(bus.acc_en) + int'(bus.acc_first) + int'(bus.output_valid)
          + int'(bus.m_rd_addr) + int'(bus.x_rd_addr), 0);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("postreset_ready", bus.input_ready, 1);
    check("postreset_acc_en", bus.acc_en, 0);
    clearLogs();
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("postreset_matrix_m_wr", m_wr_log.size(), 3);
    check("postreset_matrix_x_wr", x_wr_log.size(), 0);

    // Randomized traffic against the model.
    $display("[TB] starting random phase");
    cyc   = 0;
    start = mdl_transfers;
    while ((mdl_transfers - start) < 1000 && cyc < 80000) begin
      runCycle(($urandom_range(0, 2999) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      cyc++;
    end
    check("random_transfers_done", int'((mdl_transfers - start) >= 1000), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matvec3_ctrl.md
MATVEC3_CTRL -- requirements
Module: matvec3_ctrl

Interface
REQ-001 Parameter K, default 3, matrix dimension: K*K matrix words, K vector words, K outputs per product.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous reset, active-low: reset==0 at a rising clk edge resets the block.
REQ-004 input_valid  input  1  upstream word valid.
REQ-005 input_ready  output  1  block accepts a word this cycle.
REQ-006 new_matrix  input  1  sampled only on the first word of a transfer; 1 means K*K matrix words then K vector words follow, 0 means K vector words only.
REQ-007 m_wr_en / m_wr_addr  output  1 / 4  matrix memory write strobe and row-major address.
REQ-008 x_wr_en / x_wr_addr  output  1 / 2  vector memory write strobe and address.
REQ-009 m_rd_addr / x_rd_addr  output  4 / 2  memory read addresses; the memories have 1-cycle synchronous read.
REQ-010 acc_en / acc_first  output  1 / 1  accumulator enable; acc_first makes the accumulator load the product instead of adding it.
REQ-011 output_valid  output  1  accumulator holds a finished row result.
REQ-012 output_ready  input  1  downstream accepts the result.

Function
REQ-013 The FSM shall have states S_LOAD, S_COMP, S_DRAIN and S_OUT, with a row counter r (0..K-1) and a column counter c (0..K-1).
REQ-014 S_LOAD: input_ready=1. An accept is input_valid&&input_ready. A word counter w counts accepts.
REQ-015 The first accept of a transfer latches mode = new_matrix OR NOT m_loaded; new_matrix on later words of the transfer is ignored.
REQ-016 Matrix mode: words w=0..K*K-1 assert m_wr_en with m_wr_addr=w; words K*K..K*K+K-1 assert x_wr_en with x_wr_addr=w-K*K; m_loaded is set on the last matrix word.
REQ-017 Vector mode: words 0..K-1 assert x_wr_en with x_wr_addr=w.
REQ-018 Write strobes are combinational from the accept and shall never assert without an accept, including when input_valid is high while input_ready is low.
REQ-019 The accept of the final word of a transfer moves the FSM to S_COMP with r=0, c=0, and w clears.
REQ-020 S_COMP: m_rd_addr=r*K+c and x_rd_addr=c; c increments each cycle; after c=K-1 the FSM moves to S_DRAIN.
REQ-021 acc_en is asserted exactly one cycle after each read address is issued, i.e. in S_COMP with c>=1 and in S_DRAIN.
REQ-022 acc_first=1 only with the acc_en for c=0.
REQ-023 S_DRAIN lasts 1 cycle, then the FSM moves to S_OUT.
REQ-024 S_OUT: output_valid=1, held stable until output_ready.
REQ-025 On the output handshake with r<K-1: r increments, c=0, and the FSM moves to S_COMP.
REQ-026 On the output handshake with r=K-1: the FSM moves to S_LOAD.
REQ-027 Latency: output_valid rises after the 4th rising edge following the final-word accept edge; each following row takes 4 edges after the previous handshake.
REQ-028 input_ready=0 in all states except S_LOAD; no input is accepted during compute or output.
REQ-029 The block accepts no new transfer until all K outputs are consumed, and S_OUT has no timeout.
REQ-030 Read addresses shall be 0 outside S_COMP.

Reset
REQ-031 Reset shall apply to: state=S_LOAD, w=0, r=0, c=0, m_loaded=0, mode=0.
REQ-032 Output values in and after reset: input_ready=1 in the first cycle after reset deasserts and 0 while reset is low; all strobes, addresses, acc_en, acc_first and output_valid = 0.
REQ-033 Reset mid-transfer or mid-compute shall discard partial work; the next transfer must carry a matrix, because m_loaded=0 forces matrix mode.

Structure
REQ-034 Package matvec_pkg shall hold K, the address widths ($clog2(K*K), $clog2(K)), the state enum ctrl_state_t, and the 14b data / 28b result width constants shared with the datapath.
REQ-035 One sub-module, matvec3_cnt (a parameterised wrap counter with clear and enable), shall be instantiated for w, r and c; all other logic stays flat in one FSM.

Verification
REQ-036 Matrix path: 12 back-to-back valid words with new_matrix=1 on word 0 -> m_wr_addr 0..8, then x_wr_addr 0..2; input_ready drops the cycle after word 11; output_valid rises 4 edges later.
REQ-037 Read sequence: in row 1 -> m_rd_addr=3,4,5 with x_rd_addr=0,1,2; acc_en pulses 3 cycles delayed by 1; acc_first only on the first pulse.
REQ-038 Vector-only reuse: a transfer of 3 words with new_matrix=0 after a loaded matrix -> only x_wr_en pulses (addresses 0..2), no m_wr_en, and 3 outputs follow.
REQ-039 First transfer after reset with new_matrix=0 -> treated as matrix mode, 12 words accepted.
REQ-040 Backpressure: output_ready held low for 10 cycles in S_OUT -> output_valid stays 1, no state change, input_ready stays 0; random input_valid/output_ready toggling with 1000 transfers matches a golden model.
REQ-041 Reset low during S_COMP of row 1 -> all outputs 0 next cycle; after release input_ready=1 and the next transfer is loaded as a matrix.
